pic8259_host_master: RTL and testbench

//  CPU-side bus initiator for PIC_8259A. Translates a valid/ready command stream into 8259 register write/read

---
 rtl/pic8259_pkg.sv | 33 +++
 rtl/pic8259_strobe_timer.sv | 26 ++
 rtl/pic8259_host_master.sv | 163 ++++++++++++++++
 tb/tb_pic8259_host_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic8259_pkg.sv
// Shared types and constants for the 8259A host-side bus initiator.
// Command-byte constants let host firmware and benches build ICW/OCW words by name.
package pic8259_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STB,
    ST_RD_STB,
    ST_INTA1,
    ST_INTA_GAP,
    ST_INTA2,
    ST_RECOV
  } state_t;

  // A0 selects between the two 8259 register ports
  localparam logic PIC_A0_ICW1_OCW23 = 1'b0;
  localparam logic PIC_A0_ICW24_OCW1 = 1'b1;

  localparam logic [7:0] ICW1_IC4   = 8'h01;
  localparam logic [7:0] ICW1_SNGL  = 8'h02;
  localparam logic [7:0] ICW1_LTIM  = 8'h08;
  localparam logic [7:0] ICW1_INIT  = 8'h10;

  localparam logic [7:0] OCW2_EOI   = 8'h20;
  localparam logic [7:0] OCW2_SL    = 8'h40;
  localparam logic [7:0] OCW2_R     = 8'h80;

  localparam logic [7:0] OCW3_RIS   = 8'h01;
  localparam logic [7:0] OCW3_RR    = 8'h02;
  localparam logic [7:0] OCW3_POLL  = 8'h04;
  localparam logic [7:0] OCW3_SEL   = 8'h08;

endpackage

// File: rtl/pic8259_strobe_timer.sv
// Down-counter shared by every timed state: loaded on state entry, done on its final clock.
module pic8259_strobe_timer #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/pic8259_host_master.sv
// Host-side initiator for an 8259A: turns a valid/ready command stream into register
// read/write cycles and runs the two-pulse INTA acknowledge when INT is raised.
module pic8259_host_master
  import pic8259_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       inta_en,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       busy,
  inout  wire  [7:0] D,
  output logic       CS_n,
  output logic       A0,
  output logic       WR_n,
  output logic       RD_n,
  output logic       INTA_n,
  input  logic       INT
);

  localparam int MAX_CYCLES = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES);

  state_t           state;
  logic             int_meta;
  logic             int_sync;
  logic             ready_q;
  logic             ack_req;
  logic             accept;
  logic             d_oe;
  logic [7:0]       d_out;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;

  assign D = d_oe ? d_out : 8'hzz;

  // ready_q keeps cmd_ready low through reset and for the first clock after release
  assign ack_req   = int_sync && inta_en;
  assign cmd_ready = ready_q && (state == ST_IDLE) && !ack_req;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      int_meta <= INT;
      int_sync <= int_meta;
      ready_q  <= 1'b1;
    end
  end

  // The timer is reloaded on the same edge that enters each timed state
  always_comb begin
    timer_load  = 1'b0;
    timer_value = STB_LOAD;
    case (state)
      ST_IDLE: timer_load = ack_req || accept;
      ST_WR_STB, ST_RD_STB, ST_INTA1, ST_INTA2: begin
        timer_load  = timer_done;
        timer_value = REC_LOAD;
      end
      ST_INTA_GAP: timer_load = timer_done;
      default: timer_load = 1'b0;
    endcase
  end

  pic8259_strobe_timer #(.W(CNT_W)) u_timer (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= ST_IDLE;
      CS_n      <= 1'b1;
      A0        <= 1'b0;
      WR_n      <= 1'b1;
      RD_n      <= 1'b1;
      INTA_n    <= 1'b1;
      d_oe      <= 1'b0;
      d_out     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      vec_valid <= 1'b0;
      vec_data  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A pending acknowledge always wins over a waiting command
          if (ack_req) begin
            state  <= ST_INTA1;
            INTA_n <= 1'b0;
          end else if (accept) begin
            A0   <= cmd_a0;
            CS_n <= 1'b0;
            if (cmd_write) begin
              state <= ST_WR_STB;
              WR_n  <= 1'b0;
              d_out <= cmd_wdata;
              d_oe  <= 1'b1;
            end else begin
              state <= ST_RD_STB;
              RD_n  <= 1'b0;
            end
          end
        end
        ST_WR_STB: if (timer_done) begin
          state <= ST_RECOV;
          WR_n  <= 1'b1;
          CS_n  <= 1'b1;
          d_oe  <= 1'b0;
        end
        ST_RD_STB: if (timer_done) begin
          state     <= ST_RECOV;
          RD_n      <= 1'b1;
          CS_n      <= 1'b1;
          rsp_rdata <= D;
          rsp_valid <= 1'b1;
        end
        ST_INTA1: if (timer_done) begin
          state  <= ST_INTA_GAP;
          INTA_n <= 1'b1;
        end
        ST_INTA_GAP: if (timer_done) begin
          state  <= ST_INTA2;
          INTA_n <= 1'b0;
        end
        ST_INTA2: if (timer_done) begin
          state     <= ST_RECOV;
          INTA_n    <= 1'b1;
          vec_data  <= D;
          vec_valid <= 1'b1;
        end
        ST_RECOV: if (timer_done) begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic8259_host_master.sv
// Directed bench for pic8259_host_master with a small 8259 pin model on the shared data bus.
module tb_pic8259_host_master;
  import pic8259_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       inta_en = 1'b1;
  logic       cmd_ready, rsp_valid, vec_valid, busy;
  logic [7:0] rsp_rdata, vec_data;
  logic       CS_n, A0, WR_n, RD_n, INTA_n, INT;
  wire  [7:0] D;

  // PIC model: drives read data, the vector on even INTA pulses, and a keeper value when idle
  logic       int_req = 1'b0;
  logic       auto_drop = 1'b1;
  logic [7:0] pic_vec = 8'h00;
  logic [7:0] pic_rd = 8'h00;
  logic [7:0] inta_drv;
  int         inta_falls = 0;
  int         inta_base = 0;
  int         checks = 0;
  int         errors = 0;

  always @(negedge INTA_n) inta_falls++;

  assign INT      = int_req && !(auto_drop && (inta_falls != inta_base));
  assign inta_drv = (((inta_falls - inta_base) % 2) == 0) ? pic_vec : 8'hFF;
  assign D = !RD_n ? pic_rd :
             !INTA_n ? inta_drv :
             (WR_n ? 8'hA5 : 8'hzz);

  always #5 CLK = ~CLK;

  pic8259_host_master #(.STROBE_CYCLES(2), .RECOVERY_CYCLES(2)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .inta_en(inta_en), .vec_valid(vec_valid), .vec_data(vec_data), .busy(busy),
    .D(D), .CS_n(CS_n), .A0(A0), .WR_n(WR_n), .RD_n(RD_n), .INTA_n(INTA_n), .INT(INT)
  );

  task automatic test_reset();
    #1 RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if ({CS_n, WR_n, RD_n, INTA_n, A0} !== 5'b11110) begin
      errors++; $display("FAIL reset_pins: got %b want 11110", {CS_n, WR_n, RD_n, INTA_n, A0}); end
    checks++; if (D !== 8'hA5) begin
      errors++; $display("FAIL reset_d_released: got %h want a5 (keeper only)", D); end
    checks++; if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    checks++; if ({busy, rsp_valid, vec_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {busy, rsp_valid, vec_valid}); end
    checks++; if ({rsp_rdata, vec_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h want 0000", {rsp_rdata, vec_data}); end
    RST_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL release_ready_early: got %b want 0", cmd_ready); end
    @(negedge CLK);
    checks++; if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write(input logic [7:0] wd, input logic a0, input string name);
    int wr_low = 0;
    int bad = 0;
    int n = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = a0; cmd_wdata = wd;
    while (!cmd_ready && n < 20) begin @(negedge CLK); n++; end
    checks++; if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_timeout: got %b want 1", name, cmd_ready); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      cmd_valid = 1'b0;
      if (!WR_n) begin
        wr_low++;
        if (D !== wd || A0 !== a0 || CS_n !== 1'b0 || busy !== 1'b1 || !RD_n || !INTA_n) bad++;
      end else if (D !== 8'hA5) bad++;
    end
    checks++; if (wr_low !== 2) begin
      errors++; $display("FAIL %s_wr_width: got %0d want 2", name, wr_low); end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL %s_bus: got %0d bad samples want 0", name, bad); end
    checks++; if ({busy, cmd_ready, A0} !== {1'b0, 1'b1, a0}) begin
      errors++; $display("FAIL %s_idle: got %b want %b", name, {busy, cmd_ready, A0}, {1'b0, 1'b1, a0}); end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int nacc = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = PIC_A0_ICW24_OCW1; cmd_wdata = 8'h01;
    for (int c = 0; c < 30 && nacc < 2; c++) begin
      if (cmd_ready) begin acc[nacc] = c; nacc++; end
      @(negedge CLK);
      if (nacc == 1) cmd_wdata = 8'hFF;
      if (nacc == 2) cmd_valid = 1'b0;
    end
    checks++; if (nacc !== 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
    else begin
      checks++; if (acc[1] - acc[0] !== 5) begin
        errors++; $display("FAIL b2b_period: got %0d want 5", acc[1] - acc[0]); end
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_interrupt();
    logic [15:0] trace = '0;
    int vv = 0, vj = 0, bad = 0;
    logic ready_j2 = 1'b1;
    @(negedge CLK);
    pic_vec = 8'h23; inta_base = inta_falls; auto_drop = 1'b1; int_req = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK);
      trace[j] = INTA_n;
      if (vec_valid) begin vv++; vj = j; end
      if (!CS_n || !WR_n || !RD_n) bad++;
      if (j == 2) ready_j2 = cmd_ready;
    end
    int_req = 1'b0;
    checks++; if (trace[10:1] !== 10'b1100110011) begin
      errors++; $display("FAIL inta_pulses: got %b want 1100110011", trace[10:1]); end
    checks++; if (vv !== 1 || vj !== 9) begin
      errors++; $display("FAIL inta_vec_valid: got %0d pulses at %0d want 1 at 9", vv, vj); end
    checks++; if (vec_data !== 8'h23) begin
      errors++; $display("FAIL inta_vec_data: got %h want 23", vec_data); end
    checks++; if (bad !== 0 || ready_j2 !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL inta_side: got bad=%0d ready=%b busy=%b want 0 0 0", bad, ready_j2, busy); end
  endtask

  task automatic test_int_vs_cmd();
    int first_inta = -1, first_wr = -1, vv = 0, multi = 0;
    @(negedge CLK);
    pic_vec = 8'h24; inta_base = inta_falls; auto_drop = 1'b1; int_req = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      @(negedge CLK);
      if (!INTA_n && first_inta < 0) first_inta = j;
      if (!WR_n && first_wr < 0) begin first_wr = j; cmd_valid = 1'b0; end
      if (vec_valid) vv++;
      if ((!WR_n + !RD_n + !INTA_n) > 1) multi++;
      if (j == 2) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = PIC_A0_ICW24_OCW1; cmd_wdata = 8'hFB;
      end
    end
    int_req = 1'b0; cmd_valid = 1'b0;
    checks++; if (first_inta !== 3 || first_wr !== 12) begin
      errors++; $display("FAIL int_priority: got inta@%0d wr@%0d want 3 12", first_inta, first_wr); end
    checks++; if (vv !== 1 || vec_data !== 8'h24 || multi !== 0) begin
      errors++; $display("FAIL int_priority_vec: got %0d/%h/%0d want 1/24/0", vv, vec_data, multi); end
  endtask

  task automatic test_read();
    int rd_low = 0, rv = 0, rj = 0, bad = 0, n = 0;
    test_write(OCW3_SEL | OCW3_RR, PIC_A0_ICW1_OCW23, "ocw3");
    pic_rd = 8'h20;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_a0 = PIC_A0_ICW1_OCW23;
    while (!cmd_ready && n < 20) begin @(negedge CLK); n++; end
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      cmd_valid = 1'b0;
      if (!RD_n) begin
        rd_low++;
        if (A0 !== 1'b0 || CS_n !== 1'b0 || D !== 8'h20 || !WR_n || !INTA_n) bad++;
      end
      if (rsp_valid) begin rv++; rj = i; end
    end
    checks++; if (rd_low !== 2 || bad !== 0) begin
      errors++; $display("FAIL read_strobe: got %0d clks %0d bad want 2 0", rd_low, bad); end
    checks++; if (rv !== 1 || rj !== 3) begin
      errors++; $display("FAIL read_rsp_valid: got %0d pulses at %0d want 1 at 3", rv, rj); end
    checks++; if (rsp_rdata !== 8'h20) begin
      errors++; $display("FAIL read_rdata: got %h want 20", rsp_rdata); end
    test_write(8'hFB, PIC_A0_ICW24_OCW1, "ocw1");
    checks++; if (rsp_rdata !== 8'h20) begin
      errors++; $display("FAIL read_rdata_hold: got %h want 20", rsp_rdata); end
  endtask

  task automatic test_reset_mid_inta();
    int first = -1, vv = 0;
    @(negedge CLK);
    pic_vec = 8'h25; inta_base = inta_falls; auto_drop = 1'b0; int_req = 1'b1;
    repeat (7) @(negedge CLK);
    checks++; if (INTA_n !== 1'b0) begin
      errors++; $display("FAIL mid_inta2_low: got %b want 0", INTA_n); end
    RST_n = 1'b0;
    #1;
    checks++; if ({INTA_n, CS_n, busy, vec_valid} !== 4'b1100) begin
      errors++; $display("FAIL mid_reset_pins: got %b want 1100", {INTA_n, CS_n, busy, vec_valid}); end
    repeat (2) @(negedge CLK);
    checks++; if (vec_valid !== 1'b0 || vec_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset_vec: got %b/%h want 0/00", vec_valid, vec_data); end
    RST_n = 1'b1; inta_base = inta_falls; auto_drop = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK);
      if (!INTA_n && first < 0) first = j;
      if (vec_valid) vv++;
    end
    int_req = 1'b0;
    checks++; if (first !== 3) begin
      errors++; $display("FAIL reack_start: got %0d want 3", first); end
    checks++; if (vv !== 1 || vec_data !== 8'h25) begin
      errors++; $display("FAIL reack_vec: got %0d/%h want 1/25", vv, vec_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write(ICW1_INIT | ICW1_SNGL | ICW1_IC4, PIC_A0_ICW1_OCW23, "icw1");
    test_write(8'h20, PIC_A0_ICW24_OCW1, "icw2");
    test_back_to_back();
    test_interrupt();
    test_int_vs_cmd();
    test_read();
    test_reset_mid_inta();
    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
